// File: rtl/dsu_register_serializer.sv
// DSU register serializer: reads one scalar or vector register of a thread
// through the debug read port of the register file and streams it out to the
// debug message handler one bit per cycle, MSB first.
module dsu_register_serializer #(
    parameter int REGISTER_SIZE    = 32,
    parameter int HW_LANE          = 16,
    parameter int THREAD_NUMB      = 8,
    parameter int REGISTER_ADDRESS = 6,
    localparam int W               = REGISTER_SIZE * HW_LANE,
    localparam int THREAD_W        = $clog2(THREAD_NUMB)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dsu_en_scalar,
    input  logic                        dsu_en_vector,
    input  logic [REGISTER_ADDRESS-1:0] dsu_reg_addr,
    input  logic [THREAD_W-1:0]         dsu_thread_id,
    input  logic                        dsu_start_shift,
    output logic                        dsu_serial_reg,
    output logic                        dsu_stop_shift,
    output logic                        dsu_rf_rd_req,
    output logic                        dsu_rf_rd_vector,
    output logic [REGISTER_ADDRESS-1:0] dsu_rf_rd_addr,
    output logic [THREAD_W-1:0]         dsu_rf_rd_thread,
    input  logic                        rf_rd_valid,
    input  logic [REGISTER_SIZE-1:0]    rf_rd_scalar_data,
    input  logic [W-1:0]                rf_rd_vector_data
);

    // state   | meaning
    // IDLE    | waiting for a scalar/vector read pulse
    // REQ     | one-cycle read request to the register file
    // WAIT_RF | waiting for read data valid
    // SHIFT   | streaming the word out, one bit per enabled cycle
    // DONE    | word complete, holding stop until the handler drops shift
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] WAIT_RF = 3'd2;
    localparam logic [2:0] SHIFT   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [2:0]                  state;
    logic [W-1:0]                shreg;
    logic [CNT_W-1:0]            cnt;
    logic                        lat_vector;
    logic [REGISTER_ADDRESS-1:0] lat_addr;
    logic [THREAD_W-1:0]         lat_thread;

    // Sequencer: command latch, read request, load and bit-serial shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            lat_vector <= 1'b0;
            lat_addr   <= '0;
            lat_thread <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dsu_en_scalar || dsu_en_vector) begin
                        // Vector takes priority when both pulses coincide.
                        lat_vector <= dsu_en_vector;
                        lat_addr   <= dsu_reg_addr;
                        lat_thread <= dsu_thread_id;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT_RF;
                end
                WAIT_RF: begin
                    if (rf_rd_valid) begin
                        // Scalars are zero-extended so the full word always
                        // clears any stale upper bits in the handler.
                        shreg <= lat_vector ? rf_rd_vector_data : W'(rf_rd_scalar_data);
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (dsu_start_shift) begin
                        shreg <= {shreg[W-2:0], 1'b0};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!dsu_start_shift) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state; serial data is only live while shifting.
    always_comb begin
        dsu_serial_reg   = (state == SHIFT) ? shreg[W-1] : 1'b0;
        dsu_stop_shift   = (state == DONE);
        dsu_rf_rd_req    = (state == REQ);
        dsu_rf_rd_vector = lat_vector;
        dsu_rf_rd_addr   = lat_addr;
        dsu_rf_rd_thread = lat_thread;
    end

endmodule

// File: tb/tb_dsu_register_serializer.sv
// Bench for dsu_register_serializer: register-file responder with
// programmable latency, handler-side receive model and a word scoreboard.
module tb_dsu_register_serializer;

    localparam int RS = 32;
    localparam int HL = 16;
    localparam int TN = 8;
    localparam int RA = 6;
    localparam int W  = RS * HL;
    localparam int TW = $clog2(TN);

    logic          clk = 1'b0;
    logic          reset;
    logic          dsu_en_scalar;
    logic          dsu_en_vector;
    logic [RA-1:0] dsu_reg_addr;
    logic [TW-1:0] dsu_thread_id;
    logic          dsu_start_shift;
    logic          dsu_serial_reg;
    logic          dsu_stop_shift;
    logic          dsu_rf_rd_req;
    logic          dsu_rf_rd_vector;
    logic [RA-1:0] dsu_rf_rd_addr;
    logic [TW-1:0] dsu_rf_rd_thread;
    logic          rf_rd_valid;
    logic [RS-1:0] rf_rd_scalar_data;
    logic [W-1:0]  rf_rd_vector_data;

    dsu_register_serializer #(
        .REGISTER_SIZE(RS),
        .HW_LANE(HL),
        .THREAD_NUMB(TN),
        .REGISTER_ADDRESS(RA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dsu_en_scalar(dsu_en_scalar),
        .dsu_en_vector(dsu_en_vector),
        .dsu_reg_addr(dsu_reg_addr),
        .dsu_thread_id(dsu_thread_id),
        .dsu_start_shift(dsu_start_shift),
        .dsu_serial_reg(dsu_serial_reg),
        .dsu_stop_shift(dsu_stop_shift),
        .dsu_rf_rd_req(dsu_rf_rd_req),
        .dsu_rf_rd_vector(dsu_rf_rd_vector),
        .dsu_rf_rd_addr(dsu_rf_rd_addr),
        .dsu_rf_rd_thread(dsu_rf_rd_thread),
        .rf_rd_valid(rf_rd_valid),
        .rf_rd_scalar_data(rf_rd_scalar_data),
        .rf_rd_vector_data(rf_rd_vector_data)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Scoreboard: expected word and expected captured-bit count per command.
    logic [W-1:0] exp_q[$];
    int           exp_n_q[$];

    // Register-file responder settings.
    int            rf_lat = 1;
    logic [W-1:0]  rf_vec_val = '0;
    logic [RS-1:0] rf_sc_val = '0;

    // Handler model state.
    logic [W-1:0]  cap = '0;
    int            cap_total = 0;
    int            cap_base = 0;
    int            done_cnt = 0;
    logic          stop_prev = 1'b0;
    logic          rst_seen = 1'b0;
    int            req_count = 0;
    logic          rq_vec = 1'b0;
    logic [RA-1:0] rq_addr = '0;
    logic [TW-1:0] rq_thr = '0;

    function automatic void check_w(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endfunction

    function automatic void check_i(string tag, int obs, int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endfunction

    // Register file: answers each read request after rf_lat cycles.
    initial begin
        rf_rd_valid       = 1'b0;
        rf_rd_scalar_data = '0;
        rf_rd_vector_data = '0;
        forever begin
            @(negedge clk);
            if (dsu_rf_rd_req === 1'b1 && reset === 1'b0) begin
                @(posedge clk);
                repeat (rf_lat - 1) @(posedge clk);
                #1;
                rf_rd_valid       = 1'b1;
                rf_rd_scalar_data = rf_sc_val;
                rf_rd_vector_data = rf_vec_val;
                @(posedge clk);
                #1;
                rf_rd_valid       = 1'b0;
                rf_rd_scalar_data = '0;
                rf_rd_vector_data = '0;
            end
        end
    end

    // Handler model: captures a bit on every shift-enabled cycle until stop,
    // and checks the received word against the scoreboard when stop rises.
    initial begin
        logic [W-1:0] ew;
        int           en;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (!rst_seen && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_n_q.pop_front());
                end
                rst_seen  = 1'b1;
                stop_prev = 1'b0;
                cap_base  = cap_total;
            end else begin
                rst_seen = 1'b0;
                if (dsu_rf_rd_req) begin
                    req_count++;
                    rq_vec  = dsu_rf_rd_vector;
                    rq_addr = dsu_rf_rd_addr;
                    rq_thr  = dsu_rf_rd_thread;
                end
                if (dsu_start_shift && !dsu_stop_shift) begin
                    cap = {cap[W-2:0], dsu_serial_reg};
                    cap_total++;
                end
                if (dsu_stop_shift && !stop_prev) begin
                    if (exp_q.size() == 0) begin
                        check_i("unexpected_stop", 1, 0);
                    end else begin
                        ew = exp_q.pop_front();
                        en = exp_n_q.pop_front();
                        check_w("word", cap, ew);
                        check_i("bits_captured", cap_total - cap_base, en);
                    end
                    cap_base = cap_total;
                    done_cnt++;
                end
                stop_prev = dsu_stop_shift;
            end
        end
    end

    // One complete read command from the handler's point of view.
    task automatic do_read(input logic vec, input logic both, input logic [RA-1:0] a,
                           input logic [TW-1:0] t, input logic [W-1:0] val, input int lat,
                           input logic pause, input logic extra_en);
        logic [W-1:0] expw;
        int           r0;
        int           d0;
        int           b0;
        int           c0;
        logic         s0;
        logic         stable;
        expw       = vec ? val : W'(val[RS-1:0]);
        rf_lat     = lat;
        rf_vec_val = vec ? val : '1;
        rf_sc_val  = vec ? 32'hA5A5_A5A5 : val[RS-1:0];
        exp_q.push_back(expw);
        exp_n_q.push_back(1 + lat + W);
        r0 = req_count;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        b0 = cap_total;
        dsu_en_vector = vec;
        dsu_en_scalar = !vec || both;
        dsu_reg_addr  = a;
        dsu_thread_id = t;
        @(posedge clk);
        #1;
        dsu_en_vector   = 1'b0;
        dsu_en_scalar   = 1'b0;
        dsu_reg_addr    = '0;
        dsu_thread_id   = '0;
        dsu_start_shift = 1'b1;
        if (pause || extra_en) begin
            for (int k = 0; k < W + 200 && (cap_total - b0) < 1 + lat + 50; k++) begin
                @(negedge clk);
                #1;
            end
            check_i("mid_shift_reached", int'((cap_total - b0) >= 1 + lat + 50), 1);
            if (extra_en) begin
                @(posedge clk);
                #1;
                dsu_en_scalar = 1'b1;
                dsu_en_vector = 1'b1;
                dsu_reg_addr  = 6'd33;
                @(posedge clk);
                #1;
                dsu_en_scalar = 1'b0;
                dsu_en_vector = 1'b0;
                dsu_reg_addr  = '0;
            end
            if (pause) begin
                @(posedge clk);
                #1;
                dsu_start_shift = 1'b0;
                @(negedge clk);
                s0     = dsu_serial_reg;
                c0     = cap_total;
                stable = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (dsu_serial_reg !== s0 || dsu_stop_shift !== 1'b0) stable = 1'b0;
                end
                check_i("pause_hold", int'(stable), 1);
                check_i("pause_no_capture", cap_total - c0, 0);
                @(posedge clk);
                #1;
                dsu_start_shift = 1'b1;
            end
        end
        for (int k = 0; k < 2 * W + 200 && done_cnt == d0; k++) begin
            @(negedge clk);
            #1;
        end
        check_i("stop_seen", int'(done_cnt != d0), 1);
        check_i("req_count", req_count - r0, 1);
        check_w("req_fields", W'({rq_vec, rq_addr, rq_thr}), W'({vec, a, t}));
        @(posedge clk);
        #1;
        @(negedge clk);
        check_i("done_hold", int'(dsu_stop_shift), 1);
        @(posedge clk);
        #1;
        dsu_start_shift = 1'b0;
        @(negedge clk);
        check_i("done_wait_fall", int'(dsu_stop_shift), 1);
        @(negedge clk);
        check_i("done_to_idle", int'(dsu_stop_shift), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        int           b0;
        reset           = 1'b1;
        dsu_en_scalar   = 1'b0;
        dsu_en_vector   = 1'b0;
        dsu_reg_addr    = '0;
        dsu_thread_id   = '0;
        dsu_start_shift = 1'b0;
        #1;
        check_w("reset_state",
                W'({dsu_serial_reg, dsu_stop_shift, dsu_rf_rd_req, dsu_rf_rd_vector,
                    dsu_rf_rd_addr, dsu_rf_rd_thread}), '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Scalar read, thread 3, reg 5, latency 1.
        do_read(1'b0, 1'b0, 6'd5, 3'd3, W'(32'hDEAD_BEEF), 1, 1'b0, 1'b0);

        // Vector read, lane i = 0x1000_0000 + i, latency 4.
        v = '0;
        for (int i = 0; i < HL; i++) v[i*RS +: RS] = 32'h1000_0000 + RS'(i);
        do_read(1'b1, 1'b0, 6'd2, 3'd0, v, 4, 1'b0, 1'b0);

        // Random vector with a 10-cycle shift pause in the middle.
        for (int i = 0; i < HL; i++) v[i*RS +: RS] = $urandom;
        do_read(1'b1, 1'b0, 6'd7, 3'd6, v, 2, 1'b1, 1'b0);

        // Both enables together, plus a stray command during SHIFT.
        for (int i = 0; i < HL; i++) v[i*RS +: RS] = $urandom;
        do_read(1'b1, 1'b1, 6'd9, 3'd1, v, 3, 1'b0, 1'b1);

        // Reset in the middle of shifting an all-ones vector.
        rf_lat     = 2;
        rf_vec_val = '1;
        rf_sc_val  = '0;
        exp_q.push_back('1);
        exp_n_q.push_back(1 + 2 + W);
        @(posedge clk);
        #1;
        dsu_en_vector = 1'b1;
        dsu_reg_addr  = 6'd1;
        dsu_thread_id = 3'd2;
        @(posedge clk);
        #1;
        dsu_en_vector   = 1'b0;
        dsu_reg_addr    = '0;
        dsu_thread_id   = '0;
        dsu_start_shift = 1'b1;
        b0 = cap_total - 1;
        for (int k = 0; k < 400 && (cap_total - b0) < 104; k++) begin
            @(negedge clk);
            #1;
        end
        check_i("abort_point", cap_total - b0, 104);
        check_i("pre_reset_bit", int'(dsu_serial_reg), 1);
        #2;
        reset = 1'b1;
        #1;
        check_w("abort_outputs",
                W'({dsu_serial_reg, dsu_stop_shift, dsu_rf_rd_req, dsu_rf_rd_vector,
                    dsu_rf_rd_addr, dsu_rf_rd_thread}), '0);
        dsu_start_shift = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        do_read(1'b0, 1'b0, 6'd3, 3'd4, W'(32'h0000_0001), 1, 1'b0, 1'b0);

        // Back-to-back: all-ones vector, then a scalar that must clear it.
        do_read(1'b1, 1'b0, 6'd63, 3'd5, '1, 1, 1'b0, 1'b0);
        do_read(1'b0, 1'b0, 6'd4, 3'd7, W'(32'h0000_0005), 2, 1'b0, 1'b0);

        check_i("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
